// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encodings,
// the length-field width helper and the per-frame length clamp.
package serial_tx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Bits needed to hold a length value from 0 up to and including width.
    function automatic int lenFieldWidth(input int width);
        return $clog2(width + 1);
    endfunction

    // A requested length of 0, or anything wider than the word, means "send the full word".
    function automatic int unsigned clampLen(input int unsigned len, input int unsigned width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period clock-enable generator: a loadable down-counter that pulses
// tick_o once every load_i+1 cycles while enabled.
module bit_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] load_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] reload_q;

    assign tick_o = en_i && (cnt_q == '0);

    // Capture the period on start, then count down and reload at every tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else if (start_i) begin
            cnt_q    <= load_i;
            reload_q <= load_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= reload_q;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Single-clock serial frame transmitter. Accepts a word over valid/ready and
// shifts len bits out on dout, LSB- or MSB-first, each bit held div+1 cycles.
// Optional even-parity bit after the data: define SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = lenFieldWidth(WIDTH),
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic [LEN_W-1:0] s_len,
    input  logic             s_msb_first,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DIV_W-1:0] div,
    output logic             dout,
    output logic             frame,
    output logic             tx_busy,
    output logic             tx_done
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0] bitsLeft_q, bitsLeft_d;
    logic             msbFirst_q, msbFirst_d;
    logic             dout_q, dout_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             tick;
    logic [LEN_W-1:0] effLen;
    logic [LEN_W-1:0] alignShift;
    logic [WIDTH-1:0] loadWord;
    logic [WIDTH-1:0] shiftNext;

    // ready_q is only high in IDLE, so this is the sole capture point for the inputs.
    assign accept     = s_valid && ready_q;
    assign effLen     = LEN_W'(clampLen(32'(s_len), 32'(WIDTH)));
    // For MSB-first the word is pre-aligned so that bit len-1 sits at the top of the register.
    assign alignShift = LEN_W'(WIDTH) - effLen;
    assign loadWord   = s_msb_first ? (s_data << alignShift) : s_data;
    assign shiftNext  = msbFirst_q ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    bit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .en_i    (busy_q),
        .load_i  (div),
        .tick_o  (tick)
    );

    // Frame sequencing: next state and next registered output values.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitsLeft_d = bitsLeft_q;
        msbFirst_d = msbFirst_q;
        dout_d     = dout_q;
        frame_d    = frame_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    shift_d    = loadWord;
                    bitsLeft_d = effLen - LEN_W'(1);
                    msbFirst_d = s_msb_first;
                    dout_d     = s_msb_first ? loadWord[WIDTH-1] : loadWord[0];
                    frame_d    = 1'b1;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d   = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (tick) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d = parity_q ^ dout_q;
`endif
                    if (bitsLeft_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = ST_PARITY;
                        dout_d  = parity_q ^ dout_q;
`else
                        state_d = ST_DONE;
                        dout_d  = 1'b0;
                        frame_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        shift_d    = shiftNext;
                        bitsLeft_d = bitsLeft_q - LEN_W'(1);
                        dout_d     = msbFirst_q ? shiftNext[WIDTH-1] : shiftNext[0];
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_DONE;
                    dout_d  = 1'b0;
                    frame_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
                frame_d = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitsLeft_q <= '0;
            msbFirst_q <= 1'b0;
            dout_q     <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitsLeft_q <= bitsLeft_d;
            msbFirst_q <= msbFirst_d;
            dout_q     <= dout_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign dout    = dout_q;
    assign frame   = frame_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign s_ready = ready_q;

endmodule
